// File: rtl/hdmi_video_pkg.sv
// Shared constants for the 640x480 HDMI raster: default timing, colour-bar palette
// and the lock-qualifier FSM states.
package hdmi_video_pkg;

    localparam int COORD_W   = 12;
    localparam int MAX_TOTAL = 4096;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
    localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
    localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] RGB_RED     = 24'hFF0000;
    localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
    localparam logic [23:0] RGB_BLACK   = 24'h000000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } lock_state_e;

    function automatic int timing_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_rgb = RGB_WHITE;
            3'd1:    bar_rgb = RGB_YELLOW;
            3'd2:    bar_rgb = RGB_CYAN;
            3'd3:    bar_rgb = RGB_GREEN;
            3'd4:    bar_rgb = RGB_MAGENTA;
            3'd5:    bar_rgb = RGB_RED;
            3'd6:    bar_rgb = RGB_BLUE;
            default: bar_rgb = RGB_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/hdmi_lock_qualifier.sv
// Qualifies the PLL lock: the raster may run only after LOCK_WAIT consecutive locked
// cycles, and any lock drop returns to IDLE immediately.
module hdmi_lock_qualifier
    import hdmi_video_pkg::*;
#(
    parameter int LOCK_WAIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pll_locked_i,
    output logic run_en_o
);

    localparam int              CNT_W   = $clog2(LOCK_WAIT + 1);
    localparam logic [CNT_W-1:0] LOCK_T  = CNT_W'(LOCK_WAIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    lock_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (pll_locked_i) begin
                    cnt_d   = CNT_ONE;
                    state_d = (CNT_ONE == LOCK_T) ? ST_RUN : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!pll_locked_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_d == LOCK_T) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (!pll_locked_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign run_en_o = (state_q == ST_RUN);

endmodule

// File: rtl/hdmi_video_timing.sv
// Pixel-clock raster generator: lock-qualified h/v counters with registered sync, DE,
// coordinates and strobes. Define HDMI_TIMING_PATTERN_EN to drive colour bars on rgb.
module hdmi_video_timing
    import hdmi_video_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BP      = H_BP_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int V_FP      = V_FP_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BP      = V_BP_DEF,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int LOCK_WAIT = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pll_locked,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               line_start,
    output logic               frame_start,
    output logic               running,
    output logic [23:0]        rgb
);

    localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_width_check
        $error("hdmi_video_timing: H_TOTAL/V_TOTAL exceed the 12-bit counter range");
    end
    if (LOCK_WAIT < 1) begin : g_lock_check
        $error("hdmi_video_timing: LOCK_WAIT must be at least 1");
    end

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    logic run_en;
    logic run_active;

    hdmi_lock_qualifier #(
        .LOCK_WAIT (LOCK_WAIT)
    ) u_lock_qualifier (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_locked_i (pll_locked),
        .run_en_o     (run_en)
    );

    // A lock drop in RUN must blank the outputs on the very next edge, so gate with the raw lock.
    assign run_active = run_en && pll_locked;

    logic [COORD_W-1:0] h_q, h_d, v_q, v_d;

    always_comb begin
        h_d = '0;
        v_d = '0;
        if (run_active) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 12'd1;
            end else begin
                h_d = h_q + 12'd1;
                v_d = v_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    logic de_d, hs_act, vs_act;

    always_comb begin
        de_d   = (h_q < H_ACT) && (v_q < V_ACT);
        hs_act = (h_q >= HS_START) && (h_q < HS_END);
        vs_act = (v_q >= VS_START) && (v_q < VS_END);
    end

    logic               hsync_q, vsync_q, de_q, ls_q, fs_q, run_q;
    logic [COORD_W-1:0] x_q, y_q;

    always_ff @(posedge clk) begin
        if (!rst_n || !run_active) begin
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            de_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            hsync_q <= hs_act ? HS_POL : ~HS_POL;
            vsync_q <= vs_act ? VS_POL : ~VS_POL;
            de_q    <= de_d;
            x_q     <= h_q;
            y_q     <= v_q;
            ls_q    <= (h_q == '0);
            fs_q    <= (h_q == '0) && (v_q == '0);
            run_q   <= 1'b1;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign running     = run_q;

`ifdef HDMI_TIMING_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0]  bar_idx;
    logic [23:0] rgb_q;

    // Pixels past 8*BAR_W (integer-division remainder) stay in the last bar.
    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (h_q >= COORD_W'(k * BAR_W)) begin
                bar_idx = 3'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !run_active) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= de_d ? bar_rgb(bar_idx) : 24'h0;
        end
    end

    assign rgb = rgb_q;
`else
    assign rgb = 24'h0;
`endif

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Bench for hdmi_video_timing with full horizontal timing, a shortened frame and LOCK_WAIT=8,
// checked against a model derived from elapsed locked cycles.
module tb_hdmi_video_timing;

    localparam int HA = 640, HFP = 16, HSW = 96, HBP = 48, HT = 800;
    localparam int VA = 20,  VFP = 3,  VSW = 2,  VBP = 5,  VT = 30;
    localparam int LW = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pll_locked = 1'b0;
    logic        hsync, vsync, de, line_start, frame_start, running;
    logic [11:0] x, y;
    logic [23:0] rgb;

    int errors = 0;
    int checks = 0;

    int          streak = 0;
    int          exp_x, exp_y;
    logic        exp_run, exp_de, exp_hs, exp_vs, exp_ls, exp_fs;
    logic [23:0] exp_rgb;
    logic [23:0] palette [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    hdmi_video_timing #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
        .HS_POL (1'b0), .VS_POL (1'b0), .LOCK_WAIT (LW)
    ) dut (
        .clk (clk), .rst_n (rst_n), .pll_locked (pll_locked),
        .hsync (hsync), .vsync (vsync), .de (de), .x (x), .y (y),
        .line_start (line_start), .frame_start (frame_start),
        .running (running), .rgb (rgb)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Advance one clock. The pixel shown after an edge is the number of locked edges
    // beyond the LOCK_WAIT needed to enter RUN, folded into the raster.
    task automatic tick();
        int t;
        int bi;
        @(posedge clk);
        if (!rst_n || !pll_locked) streak = 0;
        else streak++;
        exp_run = (streak > LW);
        t       = exp_run ? streak - LW - 1 : 0;
        exp_x   = t % HT;
        exp_y   = (t / HT) % VT;
        exp_de  = exp_run && exp_x < HA && exp_y < VA;
        exp_hs  = !(exp_run && exp_x >= HA + HFP && exp_x < HA + HFP + HSW);
        exp_vs  = !(exp_run && exp_y >= VA + VFP && exp_y < VA + VFP + VSW);
        exp_ls  = exp_run && exp_x == 0;
        exp_fs  = exp_ls && exp_y == 0;
`ifdef HDMI_TIMING_PATTERN_EN
        bi      = exp_x / (HA / 8);
        if (bi > 7) bi = 7;
        exp_rgb = exp_de ? palette[bi] : 24'h0;
`else
        bi      = 0;
        exp_rgb = 24'h0 | palette[bi] & 24'h0;
`endif
        #1;
    endtask

    task automatic run_until(input int tx, input int ty, input int budget);
        int n = 0;
        while (!(exp_run && exp_x == tx && exp_y == ty) && n < budget) begin
            tick();
            n++;
        end
        if (!(exp_run && exp_x == tx && exp_y == ty)) begin
            checks++;
            errors++;
            $display("FAIL run_until: target x=%0d y=%0d not reached, dut x=%0d y=%0d running=%b", tx, ty, x, y, running);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pll_locked = 1'b1;
        repeat (4) tick();
        checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %b want 1", hsync); end
        checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %b want 1", vsync); end
        checks++; if (de !== 1'b0) begin errors++; $display("FAIL reset_de: got %b want 0", de); end
        checks++; if (x !== 12'd0 || y !== 12'd0) begin errors++; $display("FAIL reset_xy: got %0d,%0d want 0,0", x, y); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", running); end
        checks++; if (line_start !== 1'b0 || frame_start !== 1'b0 || rgb !== 24'h0) begin
            errors++; $display("FAIL reset_strobes: ls=%b fs=%b rgb=%h want 0,0,0", line_start, frame_start, rgb);
        end
    endtask

    task automatic test_lock_settle();
        rst_n = 1'b1;
        pll_locked = 1'b0;
        repeat (3) tick();
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL idle_running: got %b want 0", running); end
        pll_locked = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            checks++;
            if (running !== (i == 9) || frame_start !== (i == 9)) begin
                errors++; $display("FAIL settle_cycle%0d: running=%b fs=%b want %b", i, running, frame_start, (i == 9));
            end
        end
        checks++; if (x !== 12'd0 || y !== 12'd0 || de !== 1'b1 || line_start !== 1'b1) begin
            errors++; $display("FAIL run_entry: x=%0d y=%0d de=%b ls=%b want 0,0,1,1", x, y, de, line_start);
        end
        pll_locked = 1'b0;
        repeat (2) tick();
        pll_locked = 1'b1;
        repeat (5) tick();
        pll_locked = 1'b0;
        tick();
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL settle_abort: running=%b want 0", running); end
        pll_locked = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            checks++;
            if (running !== (i == 9) || running !== exp_run) begin
                errors++; $display("FAIL resettle_cycle%0d: running=%b want %b", i, running, (i == 9));
            end
        end
    endtask

    task automatic test_line_timing();
        int de_n = 0, hs_n = 0, ls_n = 0, hs_first = -1, hs_last = -1;
        run_until(0, 1, 2000);
        for (int i = 0; i < HT; i++) begin
            if (i > 0) tick();
            checks++;
            if (x !== exp_x[11:0] || de !== exp_de || hsync !== exp_hs || line_start !== exp_ls) begin
                errors++; $display("FAIL line_cycle%0d: x=%0d de=%b hs=%b ls=%b want %0d,%b,%b,%b",
                                   i, x, de, hsync, line_start, exp_x, exp_de, exp_hs, exp_ls);
            end
            if (de) de_n++;
            if (!hsync) begin
                hs_n++;
                if (hs_first < 0) hs_first = int'(x);
                hs_last = int'(x);
            end
            if (line_start) ls_n++;
        end
        tick();
        checks++; if (line_start !== 1'b1 || x !== 12'd0) begin errors++; $display("FAIL line_period: ls=%b x=%0d want 1,0", line_start, x); end
        checks++; if (de_n != 640) begin errors++; $display("FAIL de_count: got %0d want 640", de_n); end
        checks++; if (hs_n != 96) begin errors++; $display("FAIL hsync_width: got %0d want 96", hs_n); end
        checks++; if (hs_first != 656 || hs_last != 751) begin errors++; $display("FAIL hsync_span: got %0d..%0d want 656..751", hs_first, hs_last); end
        checks++; if (ls_n != 1) begin errors++; $display("FAIL line_start_count: got %0d want 1", ls_n); end
    endtask

    task automatic test_frame_timing();
        int period = -1, vs_n = 0, wraps = 0, px, py;
        run_until(0, 0, HT * VT + 100);
        px = int'(x);
        py = int'(y);
        for (int i = 1; i <= HT * VT + HT; i++) begin
            tick();
            checks++;
            if (y !== exp_y[11:0] || vsync !== exp_vs || frame_start !== exp_fs) begin
                errors++; $display("FAIL frame_cycle%0d: y=%0d vs=%b fs=%b want %0d,%b,%b", i, y, vsync, frame_start, exp_y, exp_vs, exp_fs);
            end
            if (frame_start && period < 0) period = i;
            if (!vsync) begin
                vs_n++;
                checks++;
                if (y < 12'd23 || y > 12'd24) begin errors++; $display("FAIL vsync_line: vsync low at y=%0d want 23..24", y); end
            end
            if (px == HT - 1 && py == VT - 1) begin
                wraps++;
                checks++;
                if (x !== 12'd0 || y !== 12'd0) begin errors++; $display("FAIL frame_wrap: got x=%0d y=%0d want 0,0", x, y); end
            end
            px = int'(x);
            py = int'(y);
        end
        checks++; if (period != HT * VT) begin errors++; $display("FAIL frame_period: got %0d want %0d", period, HT * VT); end
        checks++; if (vs_n != VSW * HT) begin errors++; $display("FAIL vsync_width: got %0d want %0d", vs_n, VSW * HT); end
        checks++; if (wraps != 1) begin errors++; $display("FAIL wrap_count: got %0d want 1", wraps); end
    endtask

    task automatic test_lock_loss();
        run_until(300, 15, HT * VT + 100);
        checks++; if (x !== 12'd300 || y !== 12'd15) begin errors++; $display("FAIL loss_pos: got %0d,%0d want 300,15", x, y); end
        pll_locked = 1'b0;
        tick();
        checks++; if (running !== 1'b0 || de !== 1'b0) begin errors++; $display("FAIL loss_run: running=%b de=%b want 0,0", running, de); end
        checks++; if (hsync !== 1'b1 || vsync !== 1'b1) begin errors++; $display("FAIL loss_sync: hs=%b vs=%b want 1,1", hsync, vsync); end
        checks++; if (x !== 12'd0 || y !== 12'd0 || line_start !== 1'b0) begin errors++; $display("FAIL loss_xy: x=%0d y=%0d ls=%b want 0,0,0", x, y, line_start); end
        tick();
        pll_locked = 1'b1;
        repeat (9) tick();
        checks++; if (running !== 1'b1 || frame_start !== 1'b1) begin errors++; $display("FAIL relock: running=%b fs=%b want 1,1", running, frame_start); end
        checks++; if (x !== 12'd0 || y !== 12'd0 || de !== 1'b1) begin errors++; $display("FAIL relock_xy: x=%0d y=%0d de=%b want 0,0,1", x, y, de); end
    endtask

    task automatic test_pattern();
        run_until(0, 2, 2000);
        for (int i = 0; i < HT; i++) begin
            if (i > 0) tick();
            checks++;
            if (rgb !== exp_rgb) begin errors++; $display("FAIL rgb_x%0d: got %h want %h", x, rgb, exp_rgb); end
`ifdef HDMI_TIMING_PATTERN_EN
            if (x == 12'd0) begin checks++; if (rgb !== 24'hFFFFFF) begin errors++; $display("FAIL bar_x0: got %h want FFFFFF", rgb); end end
            if (x == 12'd80) begin checks++; if (rgb !== 24'hFFFF00) begin errors++; $display("FAIL bar_x80: got %h want FFFF00", rgb); end end
            if (x == 12'd559) begin checks++; if (rgb !== 24'h0000FF) begin errors++; $display("FAIL bar_x559: got %h want 0000FF", rgb); end end
            if (x == 12'd639) begin checks++; if (rgb !== 24'h000000) begin errors++; $display("FAIL bar_x639: got %h want 000000", rgb); end end
`endif
            if (de === 1'b0) begin
                checks++;
                if (rgb !== 24'h0) begin errors++; $display("FAIL rgb_blank: x=%0d got %h want 000000", x, rgb); end
            end
        end
    endtask

    task automatic test_random_lock();
        for (int i = 0; i < 3000; i++) begin
            pll_locked = ($urandom_range(0, 299) != 0);
            rst_n      = ($urandom_range(0, 999) != 0);
            tick();
            checks++;
            if (running !== exp_run || x !== exp_x[11:0] || y !== exp_y[11:0] || de !== exp_de ||
                hsync !== exp_hs || vsync !== exp_vs || line_start !== exp_ls || frame_start !== exp_fs || rgb !== exp_rgb) begin
                errors++; $display("FAIL random_cycle%0d: run=%b x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b rgb=%h want %b,%0d,%0d,%b,%b,%b,%b,%b,%h",
                                   i, running, x, y, de, hsync, vsync, line_start, frame_start, rgb,
                                   exp_run, exp_x, exp_y, exp_de, exp_hs, exp_vs, exp_ls, exp_fs, exp_rgb);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_lock_settle();
        test_line_timing();
        test_frame_timing();
        test_lock_loss();
        test_pattern();
        test_random_lock();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
